// File: rtl/id_seq_tx.sv
// UART transmitter that sends a fixed ID_DATA byte sequence on each rising edge of start_i.
// Defining ID_SEQ_TX_PARITY_EN adds an even-parity bit after the data bits of every byte.
module id_seq_tx #(
  parameter int                   CLK_DIV = 434,
  parameter int                   SEQ_LEN = 10,
  parameter logic [8*SEQ_LEN-1:0] ID_DATA = "2024000000"
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic tx_o
);

  localparam int          IDX_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef ID_SEQ_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             start_prev_q, start_prev_d;

  logic [7:0] cur_byte;
  logic       bit_end;

  assign cur_byte = ID_DATA[{idx_q, 3'b000} +: 8];
  assign bit_end  = (baud_q == 16'd0);

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    start_prev_d = start_i;

    unique case (state_q)
      S_IDLE: begin
        // The done_o cycle itself may not retrigger; earliest accept is one cycle later.
        if (start_i && !start_prev_q && !done_q) begin
          state_d = S_START;
          baud_d  = BAUD_MAX;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = BAUD_MAX;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) begin
`ifdef ID_SEQ_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef ID_SEQ_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          baud_d  = BAUD_MAX;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            baud_d  = 16'd0;
            done_d  = 1'b1;
          end else begin
            state_d = S_START;
            idx_d   = idx_q + 1'b1;
            baud_d  = BAUD_MAX;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_q       <= 16'd0;
      bit_q        <= 3'd0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;

  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      S_START:    tx_o = 1'b0;
      S_DATA:     tx_o = cur_byte[bit_q];
`ifdef ID_SEQ_TX_PARITY_EN
      S_PARITY:   tx_o = ^cur_byte;
`endif
      default:    tx_o = 1'b1;
    endcase
  end

endmodule
